mp_rpcs_rx_rate_ctrl_usb4: RTL

MP_RPCS_RX_RATE_CTRL_USB4 -- requirements
Module: mp_rpcs_rx_rate_ctrl_usb4

---
 rtl/mp_rpcs_rx_rate_ctrl_usb4.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mp_rpcs_rx_rate_ctrl_usb4.sv
// USB4 PIPE Rx rate/enable controller: sequences the 4-phase PMA handshake,
// settle wait and rate-change quiesce before exposing the Rx datapath enable.
module mp_rpcs_rx_rate_ctrl_usb4 #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int ACK_TIMEOUT    = 1023,
  parameter int QUIESCE_CYCLES = 4
) (
  input  logic       pipe_clk,
  input  logic       pipe_rst_n,
  input  logic       rx_en_req,
  input  logic [1:0] pipe_rate_req,
  input  logic       pma_ack,
  input  logic       clr_err,
  output logic       rx_en,
  output logic [1:0] pipe_rate,
  output logic       pma_rx_en,
  output logic [1:0] pma_rate,
  output logic       pma_req,
  output logic       pipe_phystatus,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    EN_REQ  = 3'd1,
    SETTLE  = 3'd2,
    ACTIVE  = 3'd3,
    QUIESCE = 3'd4,
    RC_REQ  = 3'd5
  } state_t;

  // Counter holds the number of cycles already spent in the current state.
  localparam logic [9:0] SETTLE_LAST  = 10'(SETTLE_CYCLES - 1);
  localparam logic [9:0] ACK_LAST     = 10'(ACK_TIMEOUT - 1);
  localparam logic [9:0] QUIESCE_LAST = 10'(QUIESCE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [9:0] cnt, cnt_nxt;
  logic       ack_meta, ack_s;
  logic       rx_en_nxt, pma_rx_en_nxt, pma_req_nxt, phystatus_nxt, err_nxt;
  logic [1:0] pipe_rate_nxt, pma_rate_nxt;

  assign busy = (state != OFF) && (state != ACTIVE);

  always_comb begin
    state_nxt     = state;
    rx_en_nxt     = rx_en;
    pipe_rate_nxt = pipe_rate;
    pma_rx_en_nxt = pma_rx_en;
    pma_rate_nxt  = pma_rate;
    pma_req_nxt   = pma_req;
    phystatus_nxt = 1'b0;
    err_nxt       = clr_err ? 1'b0 : timeout_err;

    case (state)
      OFF: begin
        // A stale ack from a previous handshake must fall before a new request.
        if (rx_en_req && !ack_s) begin
          state_nxt     = EN_REQ;
          pma_rx_en_nxt = 1'b1;
          pma_req_nxt   = 1'b1;
          pma_rate_nxt  = pipe_rate_req;
        end
      end
      EN_REQ, RC_REQ: begin
        if (ack_s) begin
          state_nxt   = SETTLE;
          pma_req_nxt = 1'b0;
        end else if (cnt == ACK_LAST) begin
          state_nxt     = OFF;
          pma_req_nxt   = 1'b0;
          pma_rx_en_nxt = 1'b0;
          err_nxt       = 1'b1;
          phystatus_nxt = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt     = ACTIVE;
          rx_en_nxt     = 1'b1;
          pipe_rate_nxt = pma_rate;
          phystatus_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        // Disable wins over a rate change; it waits out the entry pulse so
        // phystatus never stays high for two cycles.
        if (!rx_en_req) begin
          if (!pipe_phystatus) begin
            state_nxt     = OFF;
            rx_en_nxt     = 1'b0;
            pma_rx_en_nxt = 1'b0;
            phystatus_nxt = 1'b1;
          end
        end else if (pipe_rate_req != pipe_rate) begin
          state_nxt = QUIESCE;
          rx_en_nxt = 1'b0;
        end
      end
      QUIESCE: begin
        if ((cnt >= QUIESCE_LAST) && !ack_s) begin
          state_nxt    = RC_REQ;
          pma_rate_nxt = pipe_rate_req;
          pma_req_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt     = OFF;
        rx_en_nxt     = 1'b0;
        pma_rx_en_nxt = 1'b0;
        pma_req_nxt   = 1'b0;
      end
    endcase

    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (cnt == 10'h3FF) begin
      cnt_nxt = cnt;
    end else begin
      cnt_nxt = cnt + 10'd1;
    end
  end

  always_ff @(posedge pipe_clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      state          <= OFF;
      cnt            <= '0;
      ack_meta       <= 1'b0;
      ack_s          <= 1'b0;
      rx_en          <= 1'b0;
      pipe_rate      <= 2'b00;
      pma_rx_en      <= 1'b0;
      pma_rate       <= 2'b00;
      pma_req        <= 1'b0;
      pipe_phystatus <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      ack_meta       <= pma_ack;
      ack_s          <= ack_meta;
      rx_en          <= rx_en_nxt;
      pipe_rate      <= pipe_rate_nxt;
      pma_rx_en      <= pma_rx_en_nxt;
      pma_rate       <= pma_rate_nxt;
      pma_req        <= pma_req_nxt;
      pipe_phystatus <= phystatus_nxt;
      timeout_err    <= err_nxt;
    end
  end

endmodule
